// File: rtl/jts16_mmr_wr.sv
// Replays a small table of register writes into the video MMR over the char bus.
// Latency: first char_cs strobe 3 cycles after start is sampled, then one strobe every 4 cycles.
// Backpressure: hold stalls the sequencer in LOAD; a strobe already issued is never cancelled.
module jts16_mmr_wr #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    output logic        char_cs,
    output logic [11:1] cpu_addr,
    output logic [15:0] cpu_dout,
    output logic [1:0]  dswn,
    output logic [4:0]  wr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    // Index of the final table slot; the walk stops here even without a last bit.
    localparam logic [3:0] LAST_IDX = 4'(ENTRIES - 1);

    state_t      r_state;
    logic [3:0]  r_index;
    logic [31:0] r_entry;
    logic        r_first;
    logic        r_busy;
    logic        r_done;
    logic        r_char_cs;
    logic [11:1] r_cpu_addr;
    logic [15:0] r_cpu_dout;
    logic [1:0]  r_dswn;
    logic [4:0]  r_wr_cnt;

    // Entry seen by LOAD: live table data on the first LOAD cycle, the latched copy while stalled.
    logic [31:0] w_entry;
    logic [1:0]  w_lanes;
    logic        w_unused;

    assign w_entry  = r_first ? cfg_data : r_entry;
    assign w_lanes  = w_entry[29:28];
    assign w_unused = &{1'b0, w_entry[31:30], w_entry[27:25], w_entry[16],
                        r_entry[30], r_entry[27:25], r_entry[16]};

    // Sequencer with registered outputs; strobe and byte enables default to idle every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_index    <= 4'd0;
            r_entry    <= 32'd0;
            r_first    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_char_cs  <= 1'b0;
            r_cpu_addr <= 11'd0;
            r_cpu_dout <= 16'd0;
            r_dswn     <= 2'b11;
            r_wr_cnt   <= 5'd0;
        end else begin
            r_char_cs <= 1'b0;
            r_dswn    <= 2'b11;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_FETCH;
                        r_index  <= 4'd0;
                        r_wr_cnt <= 5'd0;
                        r_busy   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // cfg_addr already shows the index; table data arrives next cycle.
                    r_state <= S_LOAD;
                    r_first <= 1'b1;
                end
                S_LOAD: begin
                    if (r_first) begin
                        r_entry <= cfg_data;
                        r_first <= 1'b0;
                    end
                    if (!hold) begin
                        r_state <= S_WRITE;
                        if (w_lanes != 2'b00) begin
                            r_char_cs  <= 1'b1;
                            r_cpu_addr <= {3'b111, w_entry[24:17]};
                            r_cpu_dout <= w_entry[15:0];
                            r_dswn     <= ~w_lanes;
                            r_wr_cnt   <= r_wr_cnt + 5'd1;
                        end
                    end
                end
                S_WRITE: begin
                    // Strobe is on the bus this cycle; hold is deliberately not looked at.
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_entry[31] || (r_index == LAST_IDX)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                        r_index <= r_index + 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign cfg_addr = r_index;
    assign char_cs  = r_char_cs;
    assign cpu_addr = r_cpu_addr;
    assign cpu_dout = r_cpu_dout;
    assign dswn     = r_dswn;
    assign wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_jts16_mmr_wr.sv
// Bench for jts16_mmr_wr: timeline model of the table replay plus literal pins.
// Latency: outputs checked on every falling edge while a sequence is being tracked.
// Backpressure: hold windows are applied from a per-cycle schedule.
module tb_jts16_mmr_wr;

    localparam int MAXC = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic        busy, done, char_cs;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [11:1] cpu_addr;
    logic [15:0] cpu_dout;
    logic [1:0]  dswn;
    logic [4:0]  wr_cnt;

    always #5 clk = ~clk;

    jts16_mmr_wr #(.ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .busy(busy), .done(done), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .char_cs(char_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .dswn(dswn), .wr_cnt(wr_cnt)
    );

    // Table memory seen by the DUT (synchronous read) and the model's private copy.
    logic [31:0] tbl  [16];
    logic [31:0] mtbl [16];
    always @(posedge clk) cfg_data <= tbl[cfg_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic last, input logic [1:0] ln,
                                        input logic [8:0] a, input logic [15:0] d);
        return {last, 1'b0, ln, 3'b000, a, d};
    endfunction

    // Expected per-cycle outputs, index = cycles after the cycle start is driven.
    logic        e_cs   [MAXC];
    logic [10:0] e_addr [MAXC];
    logic [15:0] e_dout [MAXC];
    logic [1:0]  e_dswn [MAXC];
    logic        e_busy [MAXC];
    logic        e_done [MAXC];
    logic [4:0]  e_wr   [MAXC];
    logic        e_fchk [MAXC];
    logic [3:0]  e_fidx [MAXC];
    logic [31:0] st_e   [MAXC];
    logic [10:0] m_addr = 11'd0;
    logic [15:0] m_dout = 16'd0;
    logic [4:0]  m_wr   = 5'd0;
    int run_len, h_from, h_len, corrupt_at;

    function automatic bit hold_at(input int c);
        return (c >= h_from) && (c < h_from + h_len);
    endfunction

    // Schedule: fetch cycle f, table data waits in LOAD from f+1 until hold is low,
    // the strobe cycle follows, next fetch two cycles after the strobe cycle.
    task automatic build();
        int f, c, wc, dc;
        logic [10:0] a;
        logic [15:0] d;
        logic [4:0]  w;
        for (int k = 0; k < MAXC; k++) begin
            e_cs[k] = 1'b0; e_dswn[k] = 2'b11; e_fchk[k] = 1'b0; e_fidx[k] = 4'd0;
            st_e[k] = 32'd0;
        end
        f = 1; dc = MAXC - 4;
        for (int i = 0; i < 16; i++) begin
            e_fchk[f] = 1'b1; e_fidx[f] = 4'(i);
            c = f + 1;
            while (hold_at(c)) c++;
            wc = c + 1;
            if (mtbl[i][29:28] != 2'b00) begin
                e_cs[wc] = 1'b1; e_dswn[wc] = ~mtbl[i][29:28]; st_e[wc] = mtbl[i];
            end
            if (mtbl[i][31] || i == 15) begin
                dc = wc + 2;
                break;
            end
            f = wc + 2;
        end
        a = m_addr; d = m_dout; w = m_wr;
        for (int k = 0; k < MAXC; k++) begin
            if (k == 1) w = 5'd0;
            if (e_cs[k]) begin
                a = {3'b111, st_e[k][24:17]}; d = st_e[k][15:0]; w = w + 5'd1;
            end
            e_addr[k] = a; e_dout[k] = d; e_wr[k] = w;
            e_busy[k] = (k >= 1) && (k <= dc);
            e_done[k] = (k == dc);
        end
        run_len = dc + 4;
        m_addr = a; m_dout = d; m_wr = w;
    endtask

    int rel = 0;
    bit chk_on = 1'b0;
    int obs_done;
    int          st_cyc  [$];
    logic [10:0] st_addr [$];
    logic [1:0]  st_dswn [$];
    logic [15:0] st_dout [$];

    // Single compare process: every tracked cycle against the model timeline.
    always @(negedge clk) begin
        if (chk_on && rel < MAXC) begin
            chk("char_cs", 32'(char_cs), 32'(e_cs[rel]));
            chk("dswn", 32'(dswn), 32'(e_dswn[rel]));
            chk("cpu_addr", 32'(cpu_addr), 32'(e_addr[rel]));
            chk("cpu_dout", 32'(cpu_dout), 32'(e_dout[rel]));
            chk("busy", 32'(busy), 32'(e_busy[rel]));
            chk("done", 32'(done), 32'(e_done[rel]));
            chk("wr_cnt", 32'(wr_cnt), 32'(e_wr[rel]));
            if (e_fchk[rel]) chk("cfg_addr", 32'(cfg_addr), 32'(e_fidx[rel]));
            if (char_cs) begin
                st_cyc.push_back(rel); st_addr.push_back(cpu_addr);
                st_dswn.push_back(dswn); st_dout.push_back(cpu_dout);
            end
            if (done) obs_done = rel;
        end
    end

    task automatic run_seq(input int hf, input int hl, input int extra_start, input int cor);
        h_from = hf; h_len = hl; corrupt_at = cor;
        build();
        st_cyc.delete(); st_addr.delete(); st_dswn.delete(); st_dout.delete();
        obs_done = -1;
        for (int k = 0; k < run_len; k++) begin
            @(posedge clk); #1;
            rel = k; chk_on = 1'b1;
            start = (k == 0) || (k == extra_start);
            hold = hold_at(k);
            if (k == corrupt_at) tbl[0] = 32'hDEAD_BEEF;
        end
        @(posedge clk); #1;
        chk_on = 1'b0; start = 1'b0; hold = 1'b0;
    endtask

    task automatic set_basic();
        for (int i = 0; i < 16; i++) begin
            tbl[i] = ent(1'b0, 2'b11, 9'(i * 4), 16'hF000 + 16'(i)); mtbl[i] = tbl[i];
        end
        tbl[0] = ent(1'b0, 2'b11, 9'h098, 16'h8123); mtbl[0] = tbl[0];
        tbl[1] = ent(1'b1, 2'b01, 9'h080, 16'h00AB); mtbl[1] = tbl[1];
    endtask

    initial begin
        set_basic();
        // Reset state while rst is held from time zero.
        #12;
        chk("rst char_cs", 32'(char_cs), 32'd0);
        chk("rst dswn", 32'(dswn), 32'd3);
        chk("rst cpu_addr", 32'(cpu_addr), 32'd0);
        chk("rst cpu_dout", 32'(cpu_dout), 32'd0);
        chk("rst cfg_addr", 32'(cfg_addr), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst wr_cnt", 32'(wr_cnt), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);

        // Two-entry table, plus a start pulse while busy that must be ignored.
        run_seq(1000, 0, 4, -1);
        chk("t1 strobes", 32'(st_cyc.size()), 32'd2);
        if (st_cyc.size() >= 2) begin
            chk("t1 s0 cyc", 32'(st_cyc[0]), 32'd3);
            chk("t1 s0 addr", 32'(st_addr[0]), 32'h74C);
            chk("t1 s0 dswn", 32'(st_dswn[0]), 32'd0);
            chk("t1 s0 dout", 32'(st_dout[0]), 32'h8123);
            chk("t1 s1 cyc", 32'(st_cyc[1]), 32'd7);
            chk("t1 s1 addr", 32'(st_addr[1]), 32'h740);
            chk("t1 s1 dswn", 32'(st_dswn[1]), 32'd2);
            chk("t1 s1 dout", 32'(st_dout[1]), 32'h00AB);
        end
        chk("t1 done cyc", 32'(obs_done), 32'd9);
        chk("t1 wr_cnt", 32'(wr_cnt), 32'd2);

        // Hold covers ten LOAD cycles; table entry 0 is overwritten mid-stall.
        run_seq(2, 10, -1, 4);
        chk("t2 strobes", 32'(st_cyc.size()), 32'd2);
        if (st_cyc.size() >= 1) begin
            chk("t2 s0 cyc", 32'(st_cyc[0]), 32'd13);
            chk("t2 s0 addr", 32'(st_addr[0]), 32'h74C);
            chk("t2 s0 dout", 32'(st_dout[0]), 32'h8123);
        end
        tbl[0] = mtbl[0];

        // Entry 0 with no lanes is skipped; only the upper-byte write of entry 1 appears.
        tbl[0] = ent(1'b0, 2'b00, 9'h0A0, 16'h1111); mtbl[0] = tbl[0];
        tbl[1] = ent(1'b1, 2'b10, 9'h0C4, 16'h5AA5); mtbl[1] = tbl[1];
        run_seq(1000, 0, -1, -1);
        chk("t3 strobes", 32'(st_cyc.size()), 32'd1);
        if (st_cyc.size() >= 1) begin
            chk("t3 s0 cyc", 32'(st_cyc[0]), 32'd7);
            chk("t3 s0 dswn", 32'(st_dswn[0]), 32'd1);
            chk("t3 s0 addr", 32'(st_addr[0]), 32'h762);
        end
        chk("t3 wr_cnt", 32'(wr_cnt), 32'd1);

        // Full 16-entry walk; hold rises during the first WRITE and stalls entry 1 once.
        for (int i = 0; i < 16; i++) begin
            tbl[i] = ent(1'b0, 2'((i % 3) + 1), 9'(i * 6 + 2), 16'hA500 + 16'(i));
            mtbl[i] = tbl[i];
        end
        run_seq(3, 4, -1, -1);
        chk("t4 strobes", 32'(st_cyc.size()), 32'd16);
        if (st_cyc.size() >= 2) begin
            chk("t4 s0 cyc", 32'(st_cyc[0]), 32'd3);
            chk("t4 s1 cyc", 32'(st_cyc[1]), 32'd8);
        end
        chk("t4 done cyc", 32'(obs_done), 32'd66);
        chk("t4 wr_cnt", 32'(wr_cnt), 32'd16);

        // Reset during LOAD of entry 1, then a fresh replay from entry 0.
        set_basic();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("t5 pre cfg_addr", 32'(cfg_addr), 32'd1);
        chk("t5 pre wr_cnt", 32'(wr_cnt), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5 rst char_cs", 32'(char_cs), 32'd0);
        chk("t5 rst dswn", 32'(dswn), 32'd3);
        chk("t5 rst cpu_addr", 32'(cpu_addr), 32'd0);
        chk("t5 rst cpu_dout", 32'(cpu_dout), 32'd0);
        chk("t5 rst cfg_addr", 32'(cfg_addr), 32'd0);
        chk("t5 rst busy", 32'(busy), 32'd0);
        chk("t5 rst wr_cnt", 32'(wr_cnt), 32'd0);
        @(negedge clk); @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("t5 idle char_cs", 32'(char_cs), 32'd0);
            chk("t5 idle busy", 32'(busy), 32'd0);
        end
        m_addr = 11'd0; m_dout = 16'd0; m_wr = 5'd0;
        run_seq(1000, 0, -1, -1);
        chk("t5 strobes", 32'(st_cyc.size()), 32'd2);
        chk("t5 wr_cnt", 32'(wr_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
